reg_bank_arbiter: RTL

- Arbitrates a single-port TCPC register bank between two requesters: the I2C slave front-end (port 0) and the internal PD protocol core (port 1).
- Serializes each access into a fixed 4-cycle sequence and returns read data to the winner.
- Issues a one-cycle tx_start pulse when a write to the R_TRANSMIT address completes.
- Sits between the I2C slave and the register bank in the TCPC top level.

---
 rtl/reg_bank_arbiter.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/reg_bank_arbiter.sv
// Two-port arbiter for the single-port TCPC register bank: I2C slave (port 0) vs PD core (port 1).
// Optional R_TRANSMIT write lock is enabled with `define REG_BANK_ARBITER_TX_LOCK_EN.
//
// state     | meaning
// S_IDLE    | sample requests, pick a winner, latch its access
// S_ACCESS  | bank strobe (rb_en) for the latched access
// S_CAPTURE | bank read data valid; done / tx_start pulse
// S_REST    | gap cycle so a requester can drop req after done
module reg_bank_arbiter #(
   parameter int unsigned        ADDR_W   = 8,
   parameter int unsigned        DATA_W   = 8,
   parameter logic [ADDR_W-1:0]  TX_ADDR  = ADDR_W'('h50),
   parameter int unsigned        ARB_MODE = 0
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              i2c_req_i,
   input  logic              i2c_we_i,
   input  logic [ADDR_W-1:0] i2c_addr_i,
   input  logic [DATA_W-1:0] i2c_wdata_i,
   output logic              i2c_gnt_o,
   output logic [DATA_W-1:0] i2c_rdata_o,
   output logic              i2c_done_o,
   input  logic              core_req_i,
   input  logic              core_we_i,
   input  logic [ADDR_W-1:0] core_addr_i,
   input  logic [DATA_W-1:0] core_wdata_i,
   output logic              core_gnt_o,
   output logic [DATA_W-1:0] core_rdata_o,
   output logic              core_done_o,
   output logic              rb_en_o,
   output logic              rb_we_o,
   output logic [ADDR_W-1:0] rb_addr_o,
   output logic [DATA_W-1:0] rb_wdata_o,
   input  logic [DATA_W-1:0] rb_rdata_i,
   output logic              tx_start_o
`ifdef REG_BANK_ARBITER_TX_LOCK_EN
   ,
   input  logic              tx_done_i,
   output logic              tx_busy_o,
   output logic              i2c_err_o
`endif
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ACCESS  = 2'd1,
      S_CAPTURE = 2'd2,
      S_REST    = 2'd3
   } state_t;

   state_t              state_q;
   logic                win_core_q;
   logic                last_core_q;
   logic                we_q;
   logic                tx_hit_q;
   logic                i2c_gnt_q;
   logic                core_gnt_q;
   logic                i2c_done_q;
   logic                core_done_q;
   logic                tx_start_q;
   logic [DATA_W-1:0]   i2c_rdata_q;
   logic [DATA_W-1:0]   core_rdata_q;
   logic                rb_en_q;
   logic                rb_we_q;
   logic [ADDR_W-1:0]   rb_addr_q;
   logic [DATA_W-1:0]   rb_wdata_q;

   logic                grant_core_d;
   logic                we_d;
   logic [ADDR_W-1:0]   addr_d;
   logic [DATA_W-1:0]   wdata_d;
   logic                block_d;
   logic                tx_hit_d;

`ifdef REG_BANK_ARBITER_TX_LOCK_EN
   logic                tx_busy_q;
   logic                i2c_err_q;
   logic                block_q;
`endif

   always_comb begin
      grant_core_d = 1'b0;
      if (core_req_i && !i2c_req_i) begin
         grant_core_d = 1'b1;
      end else if (core_req_i && i2c_req_i && (ARB_MODE == 1)) begin
         grant_core_d = !last_core_q;
      end
      we_d    = grant_core_d ? core_we_i    : i2c_we_i;
      addr_d  = grant_core_d ? core_addr_i  : i2c_addr_i;
      wdata_d = grant_core_d ? core_wdata_i : i2c_wdata_i;
      block_d = 1'b0;
`ifdef REG_BANK_ARBITER_TX_LOCK_EN
      // Only I2C writes to R_TRANSMIT are locked out; the core may always transmit.
      block_d = !grant_core_d && we_d && (addr_d == TX_ADDR) && tx_busy_q;
`endif
      tx_hit_d = we_d && (addr_d == TX_ADDR) && !block_d;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= S_IDLE;
         win_core_q   <= 1'b0;
         last_core_q  <= 1'b1;
         we_q         <= 1'b0;
         tx_hit_q     <= 1'b0;
         i2c_gnt_q    <= 1'b0;
         core_gnt_q   <= 1'b0;
         i2c_done_q   <= 1'b0;
         core_done_q  <= 1'b0;
         tx_start_q   <= 1'b0;
         i2c_rdata_q  <= '0;
         core_rdata_q <= '0;
         rb_en_q      <= 1'b0;
         rb_we_q      <= 1'b0;
         rb_addr_q    <= '0;
         rb_wdata_q   <= '0;
`ifdef REG_BANK_ARBITER_TX_LOCK_EN
         tx_busy_q    <= 1'b0;
         i2c_err_q    <= 1'b0;
         block_q      <= 1'b0;
`endif
      end else begin
         i2c_done_q  <= 1'b0;
         core_done_q <= 1'b0;
         tx_start_q  <= 1'b0;
`ifdef REG_BANK_ARBITER_TX_LOCK_EN
         i2c_err_q   <= 1'b0;
         // A completing R_TRANSMIT write below overrides this clear.
         if (tx_done_i) begin
            tx_busy_q <= 1'b0;
         end
`endif
         case (state_q)
            S_IDLE: begin
               if (i2c_req_i || core_req_i) begin
                  state_q     <= S_ACCESS;
                  win_core_q  <= grant_core_d;
                  last_core_q <= grant_core_d;
                  we_q        <= we_d;
                  tx_hit_q    <= tx_hit_d;
                  i2c_gnt_q   <= !grant_core_d;
                  core_gnt_q  <= grant_core_d;
                  rb_en_q     <= 1'b1;
                  rb_we_q     <= we_d && !block_d;
                  rb_addr_q   <= addr_d;
                  rb_wdata_q  <= wdata_d;
`ifdef REG_BANK_ARBITER_TX_LOCK_EN
                  block_q     <= block_d;
`endif
               end
            end
            S_ACCESS: begin
               state_q     <= S_CAPTURE;
               rb_en_q     <= 1'b0;
               rb_we_q     <= 1'b0;
               rb_addr_q   <= '0;
               rb_wdata_q  <= '0;
               i2c_done_q  <= !win_core_q;
               core_done_q <= win_core_q;
               tx_start_q  <= tx_hit_q;
`ifdef REG_BANK_ARBITER_TX_LOCK_EN
               i2c_err_q   <= block_q;
               if (tx_hit_q) begin
                  tx_busy_q <= 1'b1;
               end
`endif
            end
            S_CAPTURE: begin
               state_q    <= S_REST;
               i2c_gnt_q  <= 1'b0;
               core_gnt_q <= 1'b0;
               if (!we_q) begin
                  if (win_core_q) begin
                     core_rdata_q <= rb_rdata_i;
                  end else begin
                     i2c_rdata_q <= rb_rdata_i;
                  end
               end
            end
            S_REST: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Bank data only arrives in CAPTURE, so it is forwarded there and held from the register afterwards.
   assign i2c_rdata_o  = (state_q == S_CAPTURE && !win_core_q && !we_q) ? rb_rdata_i : i2c_rdata_q;
   assign core_rdata_o = (state_q == S_CAPTURE &&  win_core_q && !we_q) ? rb_rdata_i : core_rdata_q;

   assign i2c_gnt_o   = i2c_gnt_q;
   assign core_gnt_o  = core_gnt_q;
   assign i2c_done_o  = i2c_done_q;
   assign core_done_o = core_done_q;
   assign rb_en_o     = rb_en_q;
   assign rb_we_o     = rb_we_q;
   assign rb_addr_o   = rb_addr_q;
   assign rb_wdata_o  = rb_wdata_q;
   assign tx_start_o  = tx_start_q;
`ifdef REG_BANK_ARBITER_TX_LOCK_EN
   assign tx_busy_o   = tx_busy_q;
   assign i2c_err_o   = i2c_err_q;
`endif

endmodule
